// File: rtl/snes_bus_responder.sv
// snes_bus_responder
// Executing end of the SNES address decode. Synchronises the asynchronous
// SNES read/write strobes, issues at most one memory request per SNES bus
// cycle to the SRAM arbiter, and returns read data on the SNES data bus.
//
// Memory handshake: MEM_REQ is a level held high from the edge a request is
// issued until the edge at which MEM_ACK is sampled high or the ack timeout
// expires. A request is never withdrawn early. MEM_WE, MEM_ADDR and
// MEM_WDATA are loaded on the issuing edge and do not change while MEM_REQ
// is high. MEM_ACK is a one-cycle pulse; MEM_RDATA is sampled in that cycle.
// MEM_ACK while MEM_REQ is low has no effect.
//
// The FSM state is kept in the enum-typed signal `state` so checkers can
// bind to it directly.
module snes_bus_responder #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [7:0]  OPEN_BUS    = 8'hFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNES_RD_n,
  input  logic        SNES_WR_n,
  input  logic [7:0]  SNES_DATA_IN,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [23:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RDATA,
  output logic [7:0]  SNES_DATA_OUT,
  output logic        SNES_DATA_OE,
  output logic        BUSY,
  output logic        TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_DRIVE = 3'd2,
    WR_REQ   = 3'd3,
    RD_DRAIN = 3'd4
  } state_t;

  // Counter value at which the next un-acked cycle completes the timeout.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;

  // Strobe synchronisers: s1/s2 are the two-flop synchroniser, s3 is history.
  logic        rd_s1, rd_s2, rd_s3;
  logic        wr_s1, wr_s2, wr_s3;
  logic        rd_fall_q;
  logic        wr_rise_q;
  logic        rd_high;

  logic [7:0]  wdata_lat;
  logic [7:0]  to_cnt;
  logic        timeout;

  logic        load_req;
  logic        req_we_nxt;
  logic        cap_rdata;
  logic        cap_open;
  logic        set_err;

  logic        mem_we_q;
  logic [23:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic [7:0]  data_out_q;
  logic        err_q;

  // Synchronise strobes and register one-cycle edge pulses from stage 2 vs history.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_s1     <= 1'b1;
      rd_s2     <= 1'b1;
      rd_s3     <= 1'b1;
      wr_s1     <= 1'b1;
      wr_s2     <= 1'b1;
      wr_s3     <= 1'b1;
      rd_fall_q <= 1'b0;
      wr_rise_q <= 1'b0;
    end else begin
      rd_s1     <= SNES_RD_n;
      rd_s2     <= rd_s1;
      rd_s3     <= rd_s2;
      wr_s1     <= SNES_WR_n;
      wr_s2     <= wr_s1;
      wr_s3     <= wr_s2;
      rd_fall_q <= rd_s3 & ~rd_s2;
      wr_rise_q <= ~wr_s3 & wr_s2;
    end
  end

  // Read strobe level aligned with the edge pulses: high once RD has returned high.
  assign rd_high = rd_s3;

  // Track write data while the synchronised write strobe is low; last value wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdata_lat <= 8'h00;
    end else if (!wr_s2) begin
      wdata_lat <= SNES_DATA_IN;
    end
  end

  // Ack timeout counter: cleared when a request is issued, counts un-acked request cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt <= 8'h00;
    end else if (load_req) begin
      to_cnt <= 8'h00;
    end else if (MEM_REQ && !MEM_ACK && (to_cnt != 8'hFF)) begin
      to_cnt <= to_cnt + 8'h01;
    end
  end

  // An ack in the final cycle takes priority over the abort.
  assign timeout = !MEM_ACK && (to_cnt == TO_LAST);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and datapath load controls.
  always_comb begin
    state_nxt  = state;
    load_req   = 1'b0;
    req_we_nxt = 1'b0;
    cap_rdata  = 1'b0;
    cap_open   = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        // A read fall takes precedence over a simultaneous write rise.
        if (rd_fall_q && ROM_HIT) begin
          state_nxt  = RD_REQ;
          load_req   = 1'b1;
          req_we_nxt = 1'b0;
        end else if (wr_rise_q && ROM_HIT && IS_WRITABLE) begin
          state_nxt  = WR_REQ;
          load_req   = 1'b1;
          req_we_nxt = 1'b1;
        end
      end
      RD_REQ: begin
        if (rd_high) begin
          // SNES has already ended the read: nothing will be driven.
          if (MEM_ACK) begin
            state_nxt = IDLE;
          end else if (timeout) begin
            state_nxt = IDLE;
            set_err   = 1'b1;
          end else begin
            state_nxt = RD_DRAIN;
          end
        end else if (MEM_ACK) begin
          state_nxt = RD_DRIVE;
          cap_rdata = 1'b1;
        end else if (timeout) begin
          state_nxt = RD_DRIVE;
          cap_open  = 1'b1;
          set_err   = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (rd_high) begin
          state_nxt = IDLE;
        end
      end
      RD_DRAIN, WR_REQ: begin
        if (MEM_ACK) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request fields are loaded only when a request issues, so they stay stable while MEM_REQ is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 24'h000000;
      mem_wdata_q <= 8'h00;
    end else if (load_req) begin
      mem_we_q    <= req_we_nxt;
      mem_addr_q  <= ROM_ADDR;
      mem_wdata_q <= wdata_lat;
    end
  end

  // Read return data: arbiter data on ack, open-bus value on timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_out_q <= 8'h00;
    end else if (cap_rdata) begin
      data_out_q <= MEM_RDATA;
    end else if (cap_open) begin
      data_out_q <= OPEN_BUS;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  assign MEM_REQ       = (state == RD_REQ) || (state == RD_DRAIN) || (state == WR_REQ);
  assign MEM_WE        = mem_we_q;
  assign MEM_ADDR      = mem_addr_q;
  assign MEM_WDATA     = mem_wdata_q;
  assign SNES_DATA_OUT = data_out_q;
  assign SNES_DATA_OE  = (state == RD_DRIVE);
  assign BUSY          = (state != IDLE);
  assign TIMEOUT_ERR   = err_q;

endmodule
